// File: rtl/vram_fill_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_fill_engine_if : control, stream-source and VRAM-port bundle for the   |
// | VRAM fill engine. master = engine side, slave = environment side.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface vram_fill_engine_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  start;
  logic                  abort;
  logic [1:0]            mode;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic [DATA_WIDTH-1:0] fill_value;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_ready;
  logic                  vram_ready;
  logic                  vram_we;
  logic [ADDR_WIDTH-1:0] vram_addr;
  logic [DATA_WIDTH-1:0] vram_data;
  logic                  busy;
  logic                  done;
  logic                  aborted;

  modport master (
    input  start, abort, mode, base_addr, length, fill_value,
    input  src_valid, src_data, vram_ready,
    output src_ready, vram_we, vram_addr, vram_data, busy, done, aborted
  );

  modport slave (
    output start, abort, mode, base_addr, length, fill_value,
    output src_valid, src_data, vram_ready,
    input  src_ready, vram_we, vram_addr, vram_data, busy, done, aborted
  );
endinterface
`default_nettype wire

// File: rtl/vram_fill_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_fill_engine : writes a base/length region of VRAM with a constant,     |
// | incrementing, checkerboard or streamed byte pattern; abortable.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module vram_fill_engine #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  vram_fill_engine_if.master bus
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_FIN  = 2'd2;

  localparam logic [1:0] c_MODE_CONST   = 2'd0;
  localparam logic [1:0] c_MODE_INCR    = 2'd1;
  localparam logic [1:0] c_MODE_CHECKER = 2'd2;
  localparam logic [1:0] c_MODE_STREAM  = 2'd3;

  localparam logic [LEN_WIDTH-1:0] c_FULL_LEN = LEN_WIDTH'(1) << ADDR_WIDTH;
  localparam logic [LEN_WIDTH-1:0] c_ONE      = LEN_WIDTH'(1);

  logic [1:0]            r_state;
  logic [1:0]            r_mode;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [DATA_WIDTH-1:0] r_fill;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_index;
  logic [DATA_WIDTH-1:0] r_data_hold;
  logic                  r_aborted;

  logic                  w_run;
  logic                  w_stream;
  logic                  w_last;
  logic                  w_accept;
  logic [LEN_WIDTH-1:0]  w_len_in;
  logic [DATA_WIDTH-1:0] w_incr_off;
  logic [DATA_WIDTH-1:0] w_pattern;
  logic [DATA_WIDTH-1:0] w_data_run;

  generate
    if (DATA_WIDTH <= LEN_WIDTH) begin : g_incr_slice
      assign w_incr_off = r_index[DATA_WIDTH-1:0];
    end else begin : g_incr_zext
      assign w_incr_off = {{(DATA_WIDTH-LEN_WIDTH){1'b0}}, r_index};
    end
  endgenerate

  assign w_run    = (r_state == c_ST_RUN);
  assign w_stream = (r_mode == c_MODE_STREAM);
  assign w_last   = (r_index == (r_len - c_ONE));
  assign w_len_in = (bus.length == '0) ? c_FULL_LEN : bus.length;

  always_comb begin
    w_pattern = r_fill;
    case (r_mode)
      c_MODE_CONST:   w_pattern = r_fill;
      c_MODE_INCR:    w_pattern = r_fill + w_incr_off;
      c_MODE_CHECKER: w_pattern = r_index[0] ? ~r_fill : r_fill;
      default:        w_pattern = r_fill;
    endcase
  end

  assign w_data_run = w_stream ? bus.src_data : w_pattern;

  // Abort withdraws the write request even though address/data stay visible.
  assign bus.vram_we   = w_run & (w_stream ? bus.src_valid : 1'b1) & ~bus.abort;
  assign w_accept      = bus.vram_we & bus.vram_ready;
  assign bus.src_ready = w_run & w_stream & bus.vram_ready;

  assign bus.vram_addr = r_base + r_index[ADDR_WIDTH-1:0];
  assign bus.vram_data = w_run ? w_data_run : r_data_hold;
  assign bus.busy      = w_run;
  assign bus.done      = (r_state == c_ST_FIN);
  assign bus.aborted   = r_aborted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_IDLE;
      r_mode      <= '0;
      r_base      <= '0;
      r_fill      <= '0;
      r_len       <= '0;
      r_index     <= '0;
      r_data_hold <= '0;
      r_aborted   <= 1'b0;
    end else begin
      r_aborted <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_mode  <= bus.mode;
            r_base  <= bus.base_addr;
            r_fill  <= bus.fill_value;
            r_len   <= w_len_in;
            r_index <= '0;
            r_state <= c_ST_RUN;
          end
        end
        c_ST_RUN: begin
          if (bus.abort) begin
            r_state   <= c_ST_IDLE;
            r_aborted <= 1'b1;
          end else if (w_accept) begin
            // Index stops on the final write so the port keeps showing it.
            if (w_last) begin
              r_state <= c_ST_FIN;
            end else begin
              r_index <= r_index + c_ONE;
            end
          end
        end
        c_ST_FIN: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
      if (w_run) begin
        r_data_hold <= w_data_run;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_fill_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vram_fill_engine : vector table, random operations and reset/abort       |
// | corner sequences for vram_fill_engine, against a write-list memory model.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_vram_fill_engine;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int LW = 13;
  localparam int VRAM_SIZE = 4096;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   mem [VRAM_SIZE];
  int   byte_q [$];

  vram_fill_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  vram_fill_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] base;
    logic [12:0] length;
    logic [7:0]  fill;
    int          ready_pat;
    int          abort_at;
    int          exp_n;
    logic [11:0] exp_fa;
    logic [7:0]  exp_fd;
    logic [11:0] exp_la;
    logic [7:0]  exp_ld;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},        32'(bus.vram_we),   0);
    chk({tag, "_addr"},      32'(bus.vram_addr), 0);
    chk({tag, "_data"},      32'(bus.vram_data), 0);
    chk({tag, "_src_ready"}, 32'(bus.src_ready), 0);
    chk({tag, "_busy"},      32'(bus.busy),      0);
    chk({tag, "_done"},      32'(bus.done),      0);
    chk({tag, "_aborted"},   32'(bus.aborted),   0);
  endtask

  function automatic int ref_data(input vec_t v, input int i);
    int f = int'(v.fill);
    case (v.mode)
      2'd0: return f;
      2'd1: return (f + i) % 256;
      2'd2: return (i % 2 == 1) ? ((~f) & 255) : f;
      default: return byte_q[i];
    endcase
  endfunction

  task automatic run_op(input vec_t v, input bit use_tbl);
    int n, k, s, cyc, budget, bad;
    int exp_a [$];
    int exp_d [$];
    int img [VRAM_SIZE];
    bit hold, stall_prev, did_abort, exp_we;
    logic [11:0] pa, fa, la;
    logic [7:0]  pd, fd, ld;

    n = (v.length == 0) ? VRAM_SIZE : int'(v.length);
    for (int i = 0; i < n; i++) begin
      exp_a.push_back((int'(v.base) + i) % VRAM_SIZE);
      exp_d.push_back(ref_data(v, i));
    end
    for (int i = 0; i < VRAM_SIZE; i++) mem[i] = -1;
    k = 0; s = 0; cyc = 0; budget = 8 * n + 64;
    hold = 0; stall_prev = 0; did_abort = 0;
    pa = '0; pd = '0; fa = '0; fd = '0; la = '0; ld = '0;

    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = 1'b0; bus.mode = v.mode; bus.base_addr = v.base;
    bus.length = v.length; bus.fill_value = v.fill; bus.vram_ready = 1'b0; bus.src_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mode = 2'($urandom); bus.base_addr = 12'($urandom);
    bus.length = 13'($urandom); bus.fill_value = 8'($urandom);

    forever begin
      case (v.ready_pat)
        0: bus.vram_ready = 1'b1;
        1: bus.vram_ready = (cyc % 2 == 0);
        2: bus.vram_ready = 1'($urandom);
        default: bus.vram_ready = !(cyc == 2 || cyc == 3);
      endcase
      bus.start = ($urandom % 5 == 0);
      if (v.mode == 2'd3) begin
        if (!hold) begin
          if (s < n && ($urandom % 3) != 0) begin
            bus.src_valid = 1'b1; bus.src_data = 8'(byte_q[s]); hold = 1;
          end else begin
            bus.src_valid = 1'b0; bus.src_data = 8'($urandom);
          end
        end
      end else begin
        bus.src_valid = 1'($urandom); bus.src_data = 8'($urandom);
      end
      bus.abort = (v.abort_at >= 0 && k == v.abort_at);

      @(negedge clk);
      chk("run_busy", 32'(bus.busy), 1);
      exp_we = bus.abort ? 1'b0 : ((v.mode == 2'd3) ? bus.src_valid : 1'b1);
      chk("run_we", 32'(bus.vram_we), 32'(exp_we));
      chk("run_src_ready", 32'(bus.src_ready), 32'((v.mode == 2'd3) && bus.vram_ready));
      if (stall_prev && bus.vram_we) begin
        chk("stall_addr", 32'(bus.vram_addr), 32'(pa));
        chk("stall_data", 32'(bus.vram_data), 32'(pd));
      end
      if (bus.abort) begin
        did_abort = 1;
        break;
      end
      if (bus.vram_we && bus.vram_ready) begin
        if (k < n) begin
          chk("wr_addr", 32'(bus.vram_addr), 32'(exp_a[k]));
          chk("wr_data", 32'(bus.vram_data), 32'(exp_d[k]));
        end
        mem[int'(bus.vram_addr)] = int'(bus.vram_data);
        if (k == 0) begin fa = bus.vram_addr; fd = bus.vram_data; end
        la = bus.vram_addr; ld = bus.vram_data;
        k++;
        if (v.mode == 2'd3) begin hold = 0; s++; end
      end
      stall_prev = bus.vram_we && !bus.vram_ready;
      pa = bus.vram_addr; pd = bus.vram_data;
      if (k == n) break;
      cyc++;
      if (cyc > budget) begin
        chk("run_timeout", 32'(k), 32'(n));
        break;
      end
      @(posedge clk); #1;
    end

    // Start and abort here land in FIN or in IDLE-after-abort; both must be ignored.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = 1'b1; bus.vram_ready = 1'b1; bus.src_valid = 1'b1;
    @(negedge clk);
    chk("end_done",    32'(bus.done),    32'(!did_abort));
    chk("end_aborted", 32'(bus.aborted), 32'(did_abort));
    chk("end_busy",    32'(bus.busy),    0);
    chk("end_we",      32'(bus.vram_we), 0);
    chk("end_src_rdy", 32'(bus.src_ready), 0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.src_valid = 1'b0;
    @(negedge clk);
    chk("idle_busy",    32'(bus.busy),    0);
    chk("idle_done",    32'(bus.done),    0);
    chk("idle_aborted", 32'(bus.aborted), 0);
    if (!did_abort) begin
      chk("write_count", 32'(k), 32'(n));
      chk("hold_addr", 32'(bus.vram_addr), 32'(exp_a[n-1]));
      chk("hold_data", 32'(bus.vram_data), 32'(exp_d[n-1]));
    end
    if (use_tbl) begin
      chk("tbl_count", 32'(k), 32'(v.exp_n));
      chk("tbl_first_addr", 32'(fa), 32'(v.exp_fa));
      chk("tbl_first_data", 32'(fd), 32'(v.exp_fd));
      chk("tbl_last_addr",  32'(la), 32'(v.exp_la));
      chk("tbl_last_data",  32'(ld), 32'(v.exp_ld));
    end
    for (int i = 0; i < VRAM_SIZE; i++) img[i] = -1;
    for (int i = 0; i < k && i < n; i++) img[exp_a[i]] = exp_d[i];
    bad = 0;
    for (int i = 0; i < VRAM_SIZE; i++) if (mem[i] != img[i]) bad++;
    chk("readback_bad_words", 32'(bad), 0);
  endtask

  initial begin
    vec_t rv;
    int   n;
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = '0; bus.base_addr = '0;
    bus.length = '0; bus.fill_value = '0; bus.src_valid = 1'b0; bus.src_data = '0;
    bus.vram_ready = 1'b0;

    //            mode   base     len      fill   rdy abort  n     first            last
    vecs[0] = '{2'd0, 12'h400, 13'h3C0, 8'h20, 0, -1, 960,  12'h400, 8'h20, 12'h7BF, 8'h20};
    vecs[1] = '{2'd1, 12'hFFE, 13'd4,   8'hFE, 0, -1, 4,    12'hFFE, 8'hFE, 12'h001, 8'h01};
    vecs[2] = '{2'd2, 12'h123, 13'd0,   8'hAA, 1, -1, 4096, 12'h123, 8'hAA, 12'h122, 8'h55};
    vecs[3] = '{2'd3, 12'h800, 13'd4,   8'h00, 3, -1, 4,    12'h800, 8'h81, 12'h803, 8'h06};
    vecs[4] = '{2'd0, 12'h050, 13'd16,  8'h3C, 0, 3,  3,    12'h050, 8'h3C, 12'h052, 8'h3C};
    vecs[5] = '{2'd0, 12'h0A0, 13'd5,   8'h11, 2, -1, 5,    12'h0A0, 8'h11, 12'h0A4, 8'h11};

    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // start together with abort in IDLE must not launch
    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = 1'b1; bus.mode = 2'd0; bus.length = 13'd8; bus.base_addr = 12'h321;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", 32'(bus.busy), 0);
    chk("start_abort_we",   32'(bus.vram_we), 0);

    for (int i = 0; i < 6; i++) begin
      byte_q = '{129, 110, 0, 6};
      run_op(vecs[i], 1'b1);
    end

    for (int r = 0; r < 8; r++) begin
      rv.mode = 2'($urandom);
      rv.base = 12'($urandom);
      rv.length = 13'(1 + $urandom % 40);
      rv.fill = 8'($urandom);
      rv.ready_pat = int'($urandom % 4);
      rv.abort_at = ($urandom % 4 == 0) ? int'($urandom % int'(rv.length)) : -1;
      rv.exp_n = 0; rv.exp_fa = '0; rv.exp_fd = '0; rv.exp_la = '0; rv.exp_ld = '0;
      n = int'(rv.length);
      byte_q = {};
      for (int b = 0; b < n; b++) byte_q.push_back(int'($urandom % 256));
      run_op(rv, 1'b0);
    end

    // asynchronous reset in the middle of a run
    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = 1'b0; bus.mode = 2'd0; bus.base_addr = 12'h200;
    bus.length = 13'd100; bus.fill_value = 8'h77; bus.vram_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    chk("pre_reset_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_reset_busy",    32'(bus.busy),    0);
      chk("post_reset_done",    32'(bus.done),    0);
      chk("post_reset_aborted", 32'(bus.aborted), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
